// File: rtl/modport_pkg.sv
// Shared types and helpers for the compressed-domain elementwise compute block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package modport_pkg;

    typedef struct packed {
        int unsigned mem_bw;
        int unsigned data_width;
        int unsigned num_blocks;
        int unsigned shift;
    } config_t;

    localparam int unsigned BEAT_BITS = 64;
    localparam int unsigned LANES     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    function automatic logic [6:0] popcount(input logic [BEAT_BITS-1:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < BEAT_BITS; i++) begin
            c = c + {6'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/modport_packer.sv
// Byte-append buffer of 2*N entries: appends push_cnt bytes at the tail, then drops pop_cnt from the head.
// Latency: data_o/cnt_o show the buffer with this cycle's push applied, same cycle; pop takes effect next cycle.
// Backpressure: none internally; callers keep fill + push - pop within 2*N and push only zero-padded data.
// Ports: clk/rst (sync, active-high), clr (job restart), push_cnt_i/push_dat_i, pop_cnt_i,
//        fill_o (registered fill), data_o/cnt_o (buffer contents and count after push, before pop).
module modport_packer #(
    parameter int unsigned W  = 8,
    parameter int unsigned N  = 8,
    parameter int unsigned CW = $clog2(N + 1),
    parameter int unsigned FW = $clog2(2 * N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [CW-1:0]     push_cnt_i,
    input  logic [N*W-1:0]    push_dat_i,
    input  logic [FW-1:0]     pop_cnt_i,
    output logic [FW-1:0]     fill_o,
    output logic [2*N*W-1:0]  data_o,
    output logic [FW-1:0]     cnt_o
);

    logic [2*N*W-1:0] buf_q, buf_d;
    logic [FW-1:0]    fill_q, fill_d;
    int unsigned      app_sh, pop_sh;

    // Slots at or above fill are always zero, so appending is a plain OR.
    always_comb begin
        app_sh = 32'(fill_q) * W;
        pop_sh = 32'(pop_cnt_i) * W;
        cnt_o  = fill_q + FW'(push_cnt_i);
        data_o = buf_q | ({{(N*W){1'b0}}, push_dat_i} << app_sh);
        buf_d  = data_o >> pop_sh;
        fill_d = cnt_o - pop_cnt_i;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
        end
    end

    assign fill_o = fill_q;

endmodule

// File: rtl/modport_top.sv
// Multiplies compressed activations by dense weights, requantizes, saturates, and re-compresses to mask + packed streams.
// Latency: encoded/mask beats are registered one cycle after the block that completes them; FLUSH adds one cycle.
// Backpressure: inputs are valid/ready (readies low outside RUN); output streams cannot be stalled.
// Ports: clk, rst (sync, active-high), start, running; activations_/masks_/weights_ input streams;
//        output_data_encoded/output_valid_encoded, output_data_masks/output_valid_masks.
// Build option: RELU_EN defined -> results clamp to 0..255; undefined -> signed clamp to -128..127.
module modport_top
    import modport_pkg::*;
#(
    parameter int unsigned MEM_BW     = 64,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_BLOCKS = 64,
    parameter int unsigned SHIFT      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              running,
    input  logic [MEM_BW-1:0] activations_input,
    input  logic              activations_valid,
    output logic              activations_ready,
    input  logic [MEM_BW-1:0] masks_input,
    input  logic              masks_valid,
    output logic              masks_ready,
    input  logic [MEM_BW-1:0] weights_input,
    input  logic              weights_valid,
    output logic              weights_ready,
    output logic [MEM_BW-1:0] output_data_encoded,
    output logic              output_valid_encoded,
    output logic [MEM_BW-1:0] output_data_masks,
    output logic              output_valid_masks
);

    localparam config_t     CFG        = '{mem_bw: MEM_BW, data_width: DATA_WIDTH,
                                           num_blocks: NUM_BLOCKS, shift: SHIFT};
    localparam int unsigned DW         = CFG.data_width;
    localparam int unsigned MASK_BEATS = CFG.num_blocks / LANES;
    localparam int unsigned BI_W       = $clog2(LANES);

    state_e            state_q, state_d;
    logic [MEM_BW-1:0] mask_q, mask_d, res_mask_q, res_mask_d;
    logic              mask_vld_q, mask_vld_d;
    logic [BI_W-1:0]   blk_idx_q, blk_idx_d;
    logic [15:0]       blk_cnt_q, blk_cnt_d, mask_beats_q, mask_beats_d;
    logic [15:0]       mask_nz_q, mask_nz_d, act_bytes_q, act_bytes_d;
    logic [MEM_BW-1:0] enc_q, enc_d, msk_out_q, msk_out_d;
    logic              enc_vld_q, enc_vld_d, msk_vld_q, msk_vld_d;

    logic [LANES-1:0]    blk_mask, res_bm;
    logic [6:0]          blk_pc;
    logic                run, fire, last_in_beat, act_xfer, msk_xfer, emit;
    logic [4:0]          in_fill, in_cnt, in_pop, ob_fill, ob_cnt, ob_pop;
    logic [3:0]          in_push_cnt, ob_push_cnt, pk_cnt, src_idx;
    logic [2*MEM_BW-1:0] in_dat, ob_dat;
    logic [MEM_BW-1:0]   pk_dat, ob_push_dat;
    logic [7:0]          a_lane, y_lane;
    logic signed [7:0]   w_lane;
    logic signed [16:0]  prod, shr;

    // Handshakes. A block needs its mask, its weight beat and enough unpacked bytes in the same cycle.
    assign run               = (state_q == RUN);
    assign blk_mask          = mask_q[32'(blk_idx_q) * LANES +: LANES];
    assign blk_pc            = popcount({{(BEAT_BITS-LANES){1'b0}}, blk_mask});
    assign weights_ready     = run && mask_vld_q && ({2'b00, in_fill} >= blk_pc);
    assign fire              = weights_ready && weights_valid;
    assign last_in_beat      = (blk_idx_q == BI_W'(LANES - 1));
    assign masks_ready       = run && (mask_beats_q < 16'(MASK_BEATS)) &&
                               (!mask_vld_q || (fire && last_in_beat));
    // Only pull activation beats that masks seen so far say are needed; the padded tail is never requested.
    assign activations_ready = run && (in_fill <= 5'(LANES)) && (act_bytes_q < mask_nz_q);
    assign act_xfer          = activations_valid && activations_ready;
    assign msk_xfer          = masks_valid && masks_ready;

    assign in_push_cnt = act_xfer ? 4'(LANES) : 4'd0;
    assign in_pop      = fire ? 5'(blk_pc) : 5'd0;

    modport_packer #(.W(DW), .N(LANES)) u_unpack (
        .clk(clk), .rst(rst), .clr((state_q == IDLE) && start),
        .push_cnt_i(in_push_cnt), .push_dat_i(activations_input), .pop_cnt_i(in_pop),
        .fill_o(in_fill), .data_o(in_dat), .cnt_o(in_cnt)
    );

    // Per-lane multiply, requantize, saturate; compact nonzero results LSB-first.
    always_comb begin
        src_idx = '0;
        a_lane  = '0;
        w_lane  = '0;
        prod    = '0;
        shr     = '0;
        y_lane  = '0;
        res_bm  = '0;
        pk_dat  = '0;
        pk_cnt  = '0;
        for (int i = 0; i < LANES; i++) begin
            a_lane = blk_mask[i] ? in_dat[32'(src_idx) * DW +: DW] : 8'd0;
            if (blk_mask[i]) src_idx = src_idx + 4'd1;
            w_lane = weights_input[i*DW +: DW];
            prod   = $signed(17'({1'b0, a_lane})) * $signed(17'(w_lane));
            shr    = prod >>> CFG.shift;
`ifdef RELU_EN
            if (shr < 17'sd0)        y_lane = 8'h00;
            else if (shr > 17'sd255) y_lane = 8'hFF;
            else                     y_lane = shr[7:0];
`else
            if (shr < -17'sd128)     y_lane = 8'h80;
            else if (shr > 17'sd127) y_lane = 8'h7F;
            else                     y_lane = shr[7:0];
`endif
            if (!blk_mask[i]) y_lane = 8'h00;
            res_bm[i] = (y_lane != 8'h00);
            if (res_bm[i]) begin
                pk_dat[32'(pk_cnt) * DW +: DW] = y_lane;
                pk_cnt = pk_cnt + 4'd1;
            end
        end
    end

    assign ob_push_cnt = fire ? pk_cnt : 4'd0;
    assign ob_push_dat = fire ? pk_dat : '0;

    modport_packer #(.W(DW), .N(LANES)) u_pack (
        .clk(clk), .rst(rst), .clr((state_q == IDLE) && start),
        .push_cnt_i(ob_push_cnt), .push_dat_i(ob_push_dat), .pop_cnt_i(ob_pop),
        .fill_o(ob_fill), .data_o(ob_dat), .cnt_o(ob_cnt)
    );

    // Full beats leave as soon as they exist; FLUSH drains whatever partial beat remains.
    always_comb begin
        ob_pop = 5'd0;
        if (state_q == FLUSH)          ob_pop = ob_cnt;
        else if (ob_cnt >= 5'(LANES))  ob_pop = 5'(LANES);
        emit = (ob_pop != 5'd0);
    end

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        mask_vld_d   = mask_vld_q;
        blk_idx_d    = blk_idx_q;
        blk_cnt_d    = blk_cnt_q;
        mask_beats_d = mask_beats_q;
        mask_nz_d    = mask_nz_q;
        act_bytes_d  = act_bytes_q;
        res_mask_d   = res_mask_q;
        enc_d        = emit ? ob_dat[MEM_BW-1:0] : enc_q;
        enc_vld_d    = emit;
        msk_out_d    = msk_out_q;
        msk_vld_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = RUN;
                    mask_vld_d   = 1'b0;
                    blk_idx_d    = '0;
                    blk_cnt_d    = '0;
                    mask_beats_d = '0;
                    mask_nz_d    = '0;
                    act_bytes_d  = '0;
                end
            end
            RUN:     if (fire && (blk_cnt_q == 16'(CFG.num_blocks - 1))) state_d = FLUSH;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (msk_xfer) begin
            mask_d       = masks_input;
            mask_vld_d   = 1'b1;
            mask_beats_d = mask_beats_q + 16'd1;
            mask_nz_d    = mask_nz_q + 16'(popcount(masks_input));
        end else if (fire && last_in_beat) begin
            mask_vld_d = 1'b0;
        end
        if (act_xfer) act_bytes_d = act_bytes_q + 16'(LANES);
        if (fire) begin
            blk_idx_d = blk_idx_q + BI_W'(1);
            blk_cnt_d = blk_cnt_q + 16'd1;
            res_mask_d[32'(blk_idx_q) * LANES +: LANES] = res_bm;
            if (last_in_beat) begin
                msk_out_d = res_mask_d;
                msk_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            mask_vld_q   <= 1'b0;
            blk_idx_q    <= '0;
            blk_cnt_q    <= '0;
            mask_beats_q <= '0;
            mask_nz_q    <= '0;
            act_bytes_q  <= '0;
            res_mask_q   <= '0;
            enc_q        <= '0;
            enc_vld_q    <= 1'b0;
            msk_out_q    <= '0;
            msk_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            mask_vld_q   <= mask_vld_d;
            blk_idx_q    <= blk_idx_d;
            blk_cnt_q    <= blk_cnt_d;
            mask_beats_q <= mask_beats_d;
            mask_nz_q    <= mask_nz_d;
            act_bytes_q  <= act_bytes_d;
            res_mask_q   <= res_mask_d;
            enc_q        <= enc_d;
            enc_vld_q    <= enc_vld_d;
            msk_out_q    <= msk_out_d;
            msk_vld_q    <= msk_vld_d;
        end
    end

    // Stays high while a registered output pulse is still on the wire.
    assign running              = (state_q != IDLE) || enc_vld_q || msk_vld_q;
    assign output_data_encoded  = enc_q;
    assign output_valid_encoded = enc_vld_q;
    assign output_data_masks    = msk_out_q;
    assign output_valid_masks   = msk_vld_q;

    logic unused_bits;
    assign unused_bits = ^{in_cnt, in_dat[2*MEM_BW-1:MEM_BW], ob_fill, ob_dat[2*MEM_BW-1:MEM_BW]};

endmodule

// File: tb/tb_modport_top.sv
module tb_modport_top;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, running;
    logic [63:0] activations_input, masks_input, weights_input;
    logic        activations_valid, activations_ready, masks_valid, masks_ready;
    logic        weights_valid, weights_ready;
    logic [63:0] output_data_encoded, output_data_masks;
    logic        output_valid_encoded, output_valid_masks;

    modport_top dut (
        .clk(clk), .rst(rst), .start(start), .running(running),
        .activations_input(activations_input), .activations_valid(activations_valid),
        .activations_ready(activations_ready),
        .masks_input(masks_input), .masks_valid(masks_valid), .masks_ready(masks_ready),
        .weights_input(weights_input), .weights_valid(weights_valid), .weights_ready(weights_ready),
        .output_data_encoded(output_data_encoded), .output_valid_encoded(output_valid_encoded),
        .output_data_masks(output_data_masks), .output_valid_masks(output_valid_masks)
    );

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    logic sb_off = 1'b0;
    logic act_x = 1'b0, msk_x = 1'b0, wt_x = 1'b0;

    logic [63:0] q_enc[$];
    logic [63:0] q_msk[$];
    logic [63:0] act_beats[$];
    logic [63:0] msk_beats[$];
    logic [7:0]  bm [64];
    logic [63:0] wt [64];
    logic [7:0]  av [64][8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_y(input logic [7:0] a, input logic [7:0] w);
        int p;
        int r;
        p = int'(a) * int'($signed(w));
        r = p >>> 4;
`ifdef RELU_EN
        if (r < 0)   r = 0;
        if (r > 255) r = 255;
`else
        if (r < -128) r = -128;
        if (r > 127)  r = 127;
`endif
        return r[7:0];
    endfunction

    always @(posedge clk) begin
        act_x <= activations_valid && activations_ready;
        msk_x <= masks_valid && masks_ready;
        wt_x  <= weights_valid && weights_ready;
    end

    // Scoreboard: pop and compare whenever the DUT presents a beat.
    always @(negedge clk) begin
        if (!sb_off && output_valid_encoded) begin
            if (q_enc.size() == 0) chk("enc_extra_beat", 64'(output_valid_encoded), 64'd0);
            else                   chk("enc_beat", output_data_encoded, q_enc.pop_front());
        end
        if (!sb_off && output_valid_masks) begin
            if (q_msk.size() == 0) chk("mask_extra_beat", 64'(output_valid_masks), 64'd0);
            else                   chk("mask_beat", output_data_masks, q_msk.pop_front());
        end
    end

    task automatic set_pat(input int k);
        for (int b = 0; b < 64; b++) begin
            for (int l = 0; l < 8; l++) begin
                case (k)
                    0: begin bm[b] = 8'hFF; av[b][l] = 8'd16;  wt[b][8*l +: 8] = 8'd1;   end
                    1: begin bm[b] = 8'h00; av[b][l] = 8'd16;  wt[b][8*l +: 8] = 8'd1;   end
                    2: begin bm[b] = 8'h05; av[b][l] = (l == 0) ? 8'd32 : 8'd48;
                             wt[b][8*l +: 8] = 8'd2; end
                    3: begin bm[b] = 8'hFF; av[b][l] = 8'd16;  wt[b][8*l +: 8] = 8'hFF; end
                    4: begin bm[b] = 8'hFF; av[b][l] = 8'd255; wt[b][8*l +: 8] = 8'd127; end
                    default: begin
                        bm[b] = 8'($urandom_range(0, 255));
                        av[b][l] = 8'($urandom_range(1, 255));
                        wt[b][8*l +: 8] = 8'($urandom_range(0, 255));
                    end
                endcase
            end
        end
    endtask

    task automatic build_job();
        logic [7:0]  ob[$];
        logic [7:0]  ab[$];
        logic [63:0] beat, mi, rm;
        logic [7:0]  y;
        act_beats.delete();
        msk_beats.delete();
        mi = '0;
        rm = '0;
        for (int b = 0; b < 64; b++) begin
            mi[8*(b%8) +: 8] = bm[b];
            for (int l = 0; l < 8; l++) begin
                if (bm[b][l]) begin
                    ab.push_back(av[b][l]);
                    y = model_y(av[b][l], wt[b][8*l +: 8]);
                    if (y != 8'd0) begin
                        ob.push_back(y);
                        rm[8*(b%8) + l] = 1'b1;
                    end
                end
            end
            if (b % 8 == 7) begin
                msk_beats.push_back(mi);
                q_msk.push_back(rm);
                mi = '0;
                rm = '0;
            end
        end
        while (ab.size() > 0) begin
            beat = '0;
            for (int k = 0; k < 8; k++) if (ab.size() > 0) beat[8*k +: 8] = ab.pop_front();
            act_beats.push_back(beat);
        end
        while (ob.size() > 0) begin
            beat = '0;
            for (int k = 0; k < 8; k++) if (ob.size() > 0) beat[8*k +: 8] = ob.pop_front();
            q_enc.push_back(beat);
        end
    endtask

    task automatic run_job(input string nm);
        int t;
        build_job();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_running_high"}, 64'(running), 64'd1);
        fork
            begin
                int i = 0;
                int c = 0;
                while (i < act_beats.size() && c < 3000) begin
                    activations_valid = 1'b1;
                    activations_input = act_beats[i];
                    @(negedge clk);
                    c++;
                    if (act_x) i++;
                end
                activations_valid = 1'b0;
                if (c >= 3000) chk({nm, "_act_timeout"}, 64'(i), 64'(act_beats.size()));
            end
            begin
                int i = 0;
                int c = 0;
                while (i < msk_beats.size() && c < 3000) begin
                    masks_valid = 1'b1;
                    masks_input = msk_beats[i];
                    @(negedge clk);
                    c++;
                    if (msk_x) i++;
                end
                masks_valid = 1'b0;
                if (c >= 3000) chk({nm, "_mask_timeout"}, 64'(i), 64'(msk_beats.size()));
            end
            begin
                int i = 0;
                int c = 0;
                while (i < 64 && c < 3000) begin
                    weights_valid = 1'b1;
                    weights_input = wt[i];
                    @(negedge clk);
                    c++;
                    if (wt_x) i++;
                end
                weights_valid = 1'b0;
                if (c >= 3000) chk({nm, "_weight_timeout"}, 64'(i), 64'd64);
            end
        join
        t = 0;
        while (running && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_running_low"}, 64'(running), 64'd0);
        chk({nm, "_enc_drained"}, 64'(q_enc.size()), 64'd0);
        chk({nm, "_mask_drained"}, 64'(q_msk.size()), 64'd0);
        q_enc.delete();
        q_msk.delete();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        activations_valid = 1'b0;
        masks_valid = 1'b0;
        weights_valid = 1'b0;
        activations_input = '0;
        masks_input = '0;
        weights_input = '0;
        repeat (3) @(negedge clk);
        start = 1'b1;              // start coinciding with rst must be ignored
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_running", 64'(running), 64'd0);
        chk("rst_act_ready", 64'(activations_ready), 64'd0);
        chk("rst_mask_ready", 64'(masks_ready), 64'd0);
        chk("rst_weight_ready", 64'(weights_ready), 64'd0);
        chk("rst_enc_valid", 64'(output_valid_encoded), 64'd0);
        chk("rst_mask_valid", 64'(output_valid_masks), 64'd0);
        chk("rst_enc_data", output_data_encoded, 64'd0);
        chk("rst_mask_data", output_data_masks, 64'd0);

        set_pat(0); run_job("all_ones");
        set_pat(1); run_job("all_zero");
        set_pat(2); run_job("mask05");
        set_pat(3); run_job("neg_weight");
        set_pat(4); run_job("saturate");
        set_pat(5); run_job("random");

        // Abandon a job mid-stream with reset.
        sb_off = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        masks_valid = 1'b1;       masks_input = '1;
        weights_valid = 1'b1;     weights_input = {8{8'h01}};
        activations_valid = 1'b1; activations_input = {8{8'h10}};
        repeat (20) @(negedge clk);
        chk("midjob_running", 64'(running), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_act_ready", 64'(activations_ready), 64'd0);
        chk("midrst_mask_ready", 64'(masks_ready), 64'd0);
        chk("midrst_weight_ready", 64'(weights_ready), 64'd0);
        chk("midrst_enc_valid", 64'(output_valid_encoded), 64'd0);
        chk("midrst_mask_valid", 64'(output_valid_masks), 64'd0);
        chk("midrst_running", 64'(running), 64'd0);
        rst = 1'b0;
        masks_valid = 1'b0;
        weights_valid = 1'b0;
        activations_valid = 1'b0;
        @(negedge clk);
        sb_off = 1'b0;
        set_pat(5); run_job("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
